id_stage: RTL and testbench

Instruction-decode stage sitting directly downstream of the `taylor` fetch unit (PC + instruction ROM). It captures one fetched {PC, instruction} pair into a single-entry IF/ID pipeline register using a valid/ready handshake. It decodes the MIPS subset into registered control fields, register indices, an extended immediate and a branch/jump target for the execute stage. It supports back-pressure from execute and a flush from branch resolution.

---
 rtl/id_stage.sv | 154 +++++++++++++++
 tb/tb_id_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: single-entry IF/ID register decoding a MIPS subset into execute-stage control.
module id_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      id_rs,
  output logic [4:0]      id_rt,
  output logic [4:0]      id_dest,
  output logic [XLEN-1:0] id_imm,
  output logic [XLEN-1:0] id_target,
  output logic [3:0]      id_alu_op,
  output logic            id_alu_src,
  output logic            id_reg_write,
  output logic            id_mem_read,
  output logic            id_mem_write,
  output logic            id_mem_to_reg,
  output logic [1:0]      id_branch,
  output logic            id_illegal
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dest;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic [1:0]      branch;
    logic            illegal;
  } bundle_t;
  bundle_t q, d, idle;
  logic load, wr;
  logic [5:0] op, fn;
  logic [XLEN-1:0] pc4, sext, zext;
  assign op       = if_inst[31:26];
  assign fn       = if_inst[5:0];
  assign pc4      = if_pc + XLEN'(4);
  assign sext     = {{(XLEN-16){if_inst[15]}}, if_inst[15:0]};
  assign zext     = {{(XLEN-16){1'b0}}, if_inst[15:0]};
  assign if_ready = !id_valid || id_ready;
  assign load     = if_valid && if_ready && !flush;
  always_comb begin
    idle        = '0;
    idle.pc     = RESET_PC;
    idle.alu_op = 4'hf;
  end
  always_comb begin
    d        = '0;
    wr       = 1'b0;
    d.pc     = if_pc;
    d.rs     = if_inst[25:21];
    d.rt     = if_inst[20:16];
    d.imm    = sext;
    d.target = pc4;
    d.alu_op = 4'hf;
    case (op)
      6'h00: begin
        d.dest   = if_inst[15:11];
        d.imm    = {{(XLEN-5){1'b0}}, if_inst[10:6]};
        wr       = 1'b1;
        d.alu_op = fn == 6'h20 ? 4'd0 :
                   fn == 6'h22 ? 4'd1 :
                   fn == 6'h24 ? 4'd2 :
                   fn == 6'h25 ? 4'd3 :
                   fn == 6'h2a ? 4'd4 :
                   fn == 6'h00 ? 4'd5 : 4'hf;
        d.illegal = d.alu_op == 4'hf;
      end
      6'h08, 6'h0c, 6'h0d: begin
        d.alu_op  = op == 6'h08 ? 4'd0 : op == 6'h0c ? 4'd2 : 4'd3;
        d.imm     = op == 6'h08 ? sext : zext;
        d.alu_src = 1'b1;
        d.dest    = if_inst[20:16];
        wr        = 1'b1;
      end
      6'h23: begin
        d.alu_op     = 4'd0;
        d.alu_src    = 1'b1;
        d.mem_read   = 1'b1;
        d.mem_to_reg = 1'b1;
        d.dest       = if_inst[20:16];
        wr           = 1'b1;
      end
      6'h2b: begin
        d.alu_op    = 4'd0;
        d.alu_src   = 1'b1;
        d.mem_write = 1'b1;
      end
      6'h04, 6'h05: begin
        d.alu_op = 4'd1;
        d.branch = op == 6'h04 ? 2'd1 : 2'd2;
        d.target = pc4 + {sext[XLEN-3:0], 2'b00};
      end
      6'h02: begin
        d.branch = 2'd3;
        d.target = {pc4[XLEN-1:28], if_inst[25:0], 2'b00};
      end
      default: d.illegal = 1'b1;
    endcase
    // writes to r0 are architecturally dropped, which makes 0x00000000 a NOP
    d.reg_write = wr && d.dest != 5'd0 && !d.illegal;
    if (d.illegal) begin
      d.alu_op     = 4'hf;
      d.alu_src    = 1'b0;
      d.dest       = 5'd0;
      d.mem_read   = 1'b0;
      d.mem_write  = 1'b0;
      d.mem_to_reg = 1'b0;
      d.branch     = 2'd0;
    end
  end
  // an empty register always holds the idle bundle so control bits read 0 while invalid
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      q        <= idle;
    end else if (load) begin
      id_valid <= 1'b1;
      q        <= d;
    end else if (flush || id_ready || !id_valid) begin
      id_valid <= 1'b0;
      q        <= idle;
    end
  end
  assign id_pc         = q.pc;
  assign id_rs         = q.rs;
  assign id_rt         = q.rt;
  assign id_dest       = q.dest;
  assign id_imm        = q.imm;
  assign id_target     = q.target;
  assign id_alu_op     = q.alu_op;
  assign id_alu_src    = q.alu_src;
  assign id_reg_write  = q.reg_write;
  assign id_mem_read   = q.mem_read;
  assign id_mem_write  = q.mem_write;
  assign id_mem_to_reg = q.mem_to_reg;
  assign id_branch     = q.branch;
  assign id_illegal    = q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed plus randomized checks of id_stage against a behavioural decode model.
module tb_id_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, if_valid, if_ready, flush, id_valid, id_ready;
  logic [31:0] if_pc, if_inst, id_pc, id_imm, id_target;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_branch;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_illegal;
  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_inst(if_inst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_imm(id_imm),
    .id_target(id_target), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_illegal(id_illegal)
  );
  typedef struct {
    logic [31:0] pc, imm, target;
    logic [4:0]  rs, rt, dest;
    logic [3:0]  alu;
    logic [1:0]  br;
    logic        src, wr, mr, mw, m2r, ill;
    bit          c_dest, c_imm, c_src;
  } exp_t;
  int   total = 0, bad = 0;
  exp_t m;
  bit   mv = 0, after_rst = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask
  function automatic exp_t ref_dec(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    int   simm;
    bit   writes;
    logic [5:0] op, fn;
    op       = inst[31:26];
    fn       = inst[5:0];
    simm     = int'($signed(inst[15:0]));
    writes   = 0;
    e        = '{default: '0};
    e.alu    = 4'd15;
    e.pc     = pc;
    e.rs     = inst[25:21];
    e.rt     = inst[20:16];
    e.target = pc + 32'd4;
    if (op == 6'h00) begin
      case (fn)
        6'h20: e.alu = 4'd0;
        6'h22: e.alu = 4'd1;
        6'h24: e.alu = 4'd2;
        6'h25: e.alu = 4'd3;
        6'h2a: e.alu = 4'd4;
        6'h00: e.alu = 4'd5;
        default: e.ill = 1;
      endcase
      e.dest = inst[15:11];
      e.c_dest = 1;
      e.c_src = 1;
      writes = 1;
      if (fn == 6'h00) begin
        e.imm = 32'(inst[10:6]);
        e.c_imm = 1;
      end
    end else begin
      case (op)
        6'h08, 6'h0c, 6'h0d, 6'h23: begin
          e.alu = op == 6'h08 || op == 6'h23 ? 4'd0 : op == 6'h0c ? 4'd2 : 4'd3;
          e.imm = op == 6'h0c || op == 6'h0d ? 32'(inst[15:0]) : 32'(simm);
          e.src = 1;
          e.dest = inst[20:16];
          e.mr = op == 6'h23;
          e.m2r = op == 6'h23;
          writes = 1;
        end
        6'h2b: begin
          e.alu = 4'd0;
          e.imm = 32'(simm);
          e.src = 1;
          e.mw = 1;
        end
        6'h04, 6'h05: begin
          e.alu = 4'd1;
          e.imm = 32'(simm);
          e.br = op == 6'h04 ? 2'd1 : 2'd2;
          e.target = pc + 32'd4 + 32'(simm * 4);
        end
        6'h02: begin
          e.br = 2'd3;
          e.target = ((pc + 32'd4) & 32'hF000_0000) | (32'(inst[25:0]) * 32'd4);
        end
        default: e.ill = 1;
      endcase
      e.c_dest = writes;
      e.c_imm = op != 6'h02;
      e.c_src = op != 6'h02;
    end
    if (e.ill) begin
      e = '{default: '0, pc: pc, rs: inst[25:21], rt: inst[20:16], target: pc + 32'd4, alu: 4'd15, ill: 1, c_src: 1};
    end else begin
      e.wr = writes && e.dest != 5'd0;
    end
    return e;
  endfunction
  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    logic [5:0]  ops [11];
    logic [5:0]  fns [6];
    int s;
    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0c, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
    x = $urandom;
    s = $urandom_range(0, 11);
    if (s == 11) return x;
    x[31:26] = ops[s];
    if (ops[s] == 6'h00 && $urandom_range(0, 7) != 0) x[5:0] = fns[$urandom_range(0, 5)];
    if ($urandom_range(0, 7) == 0) x[20:11] = '0;
    return x;
  endfunction
  task automatic cmp_out();
    check("valid", id_valid, mv);
    if (!mv) begin
      check("idle_pc", id_pc, 32'h0);
      check("idle_wr", id_reg_write, 0);
      check("idle_mr", id_mem_read, 0);
      check("idle_mw", id_mem_write, 0);
      check("idle_m2r", id_mem_to_reg, 0);
      check("idle_br", id_branch, 0);
      if (after_rst) begin
        check("rst_alu", id_alu_op, 15);
        check("rst_imm", id_imm, 0);
        check("rst_tgt", id_target, 0);
        check("rst_idx", {id_rs, id_rt, id_dest}, 0);
        check("rst_misc", {id_alu_src, id_illegal}, 0);
      end
    end else begin
      check("pc", id_pc, m.pc);
      check("rs", id_rs, m.rs);
      check("rt", id_rt, m.rt);
      check("alu", id_alu_op, m.alu);
      check("wr", id_reg_write, m.wr);
      check("mr", id_mem_read, m.mr);
      check("mw", id_mem_write, m.mw);
      check("m2r", id_mem_to_reg, m.m2r);
      check("br", id_branch, m.br);
      check("ill", id_illegal, m.ill);
      check("tgt", id_target, m.target);
      if (m.c_dest) check("dest", id_dest, m.dest);
      if (m.c_imm) check("imm", id_imm, m.imm);
      if (m.c_src) check("src", id_alu_src, m.src);
    end
  endtask
  task automatic cyc(input bit r, input bit v, input logic [31:0] pc, input logic [31:0] inst,
                     input bit f, input bit rd);
    rst = r;
    if_valid = v;
    if_pc = pc;
    if_inst = inst;
    flush = f;
    id_ready = rd;
    #1 check("if_ready", if_ready, !mv || rd);
    @(posedge clk);
    if (r) mv = 0;
    else if (v && (!mv || rd) && !f) begin
      mv = 1;
      m = ref_dec(pc, inst);
    end else if (f || rd) mv = 0;
    after_rst = r;
    @(negedge clk);
    cmp_out();
  endtask
  initial begin
    rst = 1; if_valid = 0; if_pc = 0; if_inst = 0; flush = 0; id_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0, 32'h2010_0005, 0, 1);
    check("tp_addi", {27'(id_dest), id_rs}, {27'd16, 5'd0});
    check("tp_addi_imm", id_imm, 32'h5);
    check("tp_addi_tgt", id_target, 32'h4);
    cyc(0, 1, 32'h4, 32'h012A_4820, 0, 1);
    check("tp_add", {id_alu_op, id_dest}, {4'd0, 5'd9});
    cyc(0, 1, 32'h8, 32'h012A_4822, 0, 1);
    check("tp_sub", {id_alu_op, id_dest}, {4'd1, 5'd9});
    cyc(0, 1, 32'h14, 32'h112A_002A, 0, 1);
    check("tp_beq_tgt", id_target, 32'hC0);
    cyc(0, 1, 32'h0, 32'h1000_FFFF, 0, 1);
    check("tp_wrap_tgt", id_target, 32'h0);
    cyc(0, 1, 32'h20, 32'h8C0A_0000, 0, 1);
    repeat (3) cyc(0, 1, 32'h24, 32'h34E7_00FF, 0, 0);
    check("tp_lw_hold", {id_mem_read, id_mem_to_reg, 5'(id_dest)}, {1'b1, 1'b1, 5'd10});
    cyc(0, 1, 32'h24, 32'h34E7_00FF, 0, 1);
    check("tp_ori", {id_imm, id_alu_op, 5'(id_dest)}, {32'hFF, 4'd3, 5'd7});
    cyc(0, 1, 32'h28, 32'h012A_4820, 1, 0);
    check("tp_flush", id_valid, 0);
    cyc(0, 1, 32'h2C, 32'hFC00_0000, 0, 1);
    check("tp_illegal", {id_illegal, id_reg_write, id_mem_read, id_mem_write, id_branch}, 6'b100000);
    cyc(0, 1, 32'h30, 32'h8C0A_0000, 0, 1);
    cyc(0, 1, 32'h34, 32'h0000_0000, 0, 0);
    cyc(1, 1, 32'h34, 32'h0000_0000, 0, 0);
    check("tp_rst_hold", {id_valid, id_alu_op}, {1'b0, 4'd15});
    cyc(0, 1, 32'h38, 32'h0000_0000, 0, 1);
    check("tp_nop_wr", id_reg_write, 0);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom & ~32'd3,
          rand_inst(), $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
